// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared entry layout, table depth, FSM states and fade helper
package rgb_led_pkg;
  localparam int SEQ_DEPTH = 8;
  localparam int ENTRY_W = 40;
  localparam int RGB_LSB = 16;
  localparam int RGB_W = 24;
  localparam int DUR_LSB = 4;
  localparam int DUR_W = 12;
  localparam int FADE_BIT = 3;
  localparam int BLINK_BIT = 2;
  localparam int LAST_BIT = 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  function automatic logic [RGB_W-1:0] fade_step(input logic [RGB_W-1:0] cur, input logic [RGB_W-1:0] tgt);
    logic [RGB_W-1:0] r;
    for (int i = 0; i < 3; i++)
      r[i*8 +: 8] = cur[i*8 +: 8] < tgt[i*8 +: 8] ? cur[i*8 +: 8] + 8'd1 :
                    cur[i*8 +: 8] > tgt[i*8 +: 8] ? cur[i*8 +: 8] - 8'd1 : cur[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one tick every TICK_DIV clocks, clearable
module tick_gen #(
  parameter int TICK_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  // count 0..TICK_DIV-1 and wrap; clr restarts the period
  always_ff @(posedge clk)
    cnt <= rst || clr || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: plays an 8-entry colour/duration table to a PWM LED driver
module rgb_led_sequencer
  import rgb_led_pkg::*;
#(
  parameter int TICK_DIV = 27000,
  parameter int DEPTH = SEQ_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [RGB_W-1:0]   rgb,
  output logic               blink_en,
  output logic               busy,
  output logic               done,
  output logic [2:0]         step_idx
);
  logic [ENTRY_W-1:0] tbl [DEPTH];
  state_t state, state_d;
  logic [ENTRY_W-1:0] cur, cur_d, ent;
  logic [DUR_W-1:0] dcnt, dcnt_d;
  logic [RGB_W-1:0] rgb_d, cur_rgb;
  logic blink_d, busy_d, done_d, tick, expire, final_e, unused_ok;
  logic [2:0] idx_d;
  assign ent = tbl[step_idx];
  assign cur_rgb = cur[RGB_LSB +: RGB_W];
  assign expire = state == RUN && tick && {1'b0, dcnt} + 13'd1 >= {1'b0, cur[DUR_LSB +: DUR_W]};
  assign final_e = cur[LAST_BIT] || step_idx == 3'd7;
  assign unused_ok = ^{ent[0], cur[BLINK_BIT], cur[0]};
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(state != RUN), .tick(tick));
  // table is written in any state and never cleared
  always_ff @(posedge clk)
    if (wr_en) tbl[wr_addr] <= wr_data;
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rgb <= '0;
      blink_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      step_idx <= '0;
      cur <= '0;
      dcnt <= '0;
    end else begin
      state <= state_d;
      rgb <= rgb_d;
      blink_en <= blink_d;
      busy <= busy_d;
      done <= done_d;
      step_idx <= idx_d;
      cur <= cur_d;
      dcnt <= dcnt_d;
    end
  end
  // next state: stop aborts to dark IDLE, LOAD latches an entry, RUN fades and times it
  always_comb begin
    state_d = state;
    rgb_d = rgb;
    blink_d = blink_en;
    busy_d = busy;
    done_d = 1'b0;
    idx_d = step_idx;
    cur_d = cur;
    dcnt_d = dcnt;
    if (stop && state != IDLE) begin
      state_d = IDLE;
      rgb_d = '0;
      blink_d = 1'b0;
      busy_d = 1'b0;
    end else if (state == IDLE) begin
      if (start && !stop) begin
        state_d = LOAD;
        busy_d = 1'b1;
        idx_d = '0;
      end
    end else if (state == LOAD) begin
      state_d = RUN;
      cur_d = ent;
      dcnt_d = '0;
      blink_d = ent[BLINK_BIT];
      rgb_d = ent[FADE_BIT] ? rgb : ent[RGB_LSB +: RGB_W];
    end else if (tick) begin
      dcnt_d = dcnt + 1'b1;
      rgb_d = expire ? cur_rgb : cur[FADE_BIT] ? fade_step(rgb, cur_rgb) : rgb;
      if (expire) begin
        state_d = final_e && !loop_en ? IDLE : LOAD;
        done_d = final_e && !loop_en;
        busy_d = !(final_e && !loop_en);
        idx_d = !final_e ? step_idx + 3'd1 : loop_en ? 3'd0 : step_idx;
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: directed and random sequences checked against a timeline model
module tb_rgb_led_sequencer;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst, wr_en, start, stop, loop_en;
  logic [2:0] wr_addr;
  logic [39:0] wr_data;
  logic [23:0] rgb;
  logic blink_en, busy, done;
  logic [2:0] step_idx;
  int n_err = 0;
  int n_chk = 0;
  logic [39:0] tt [8];
  logic [23:0] m_rgb;
  logic m_blk;
  int e_rgb[$], e_blk[$], e_busy[$], e_done[$], e_idx[$], e_pass[$];

  always #5 clk = ~clk;

  rgb_led_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .rgb(rgb), .blink_en(blink_en),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] approach(logic [23:0] a, logic [23:0] t, int s);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) begin
      int x, y;
      x = int'(a[i*8 +: 8]);
      y = int'(t[i*8 +: 8]);
      r[i*8 +: 8] = 8'(x < y ? (x + s < y ? x + s : y) : (x - s > y ? x - s : y));
    end
    return r;
  endfunction

  task automatic push(logic [23:0] c, logic b, int bz, int dn, int k, int p);
    e_rgb.push_back(int'(c));
    e_blk.push_back(int'(b));
    e_busy.push_back(bz);
    e_done.push_back(dn);
    e_idx.push_back(k);
    e_pass.push_back(p);
  endtask

  // expected per-cycle outputs from the cycle after start: one LOAD cycle per entry,
  // then max(dur,1)*TD run cycles; fades advance one step per elapsed tick
  task automatic build(int passes);
    logic [23:0] c;
    logic b;
    c = m_rgb;
    b = m_blk;
    e_rgb.delete(); e_blk.delete(); e_busy.delete();
    e_done.delete(); e_idx.delete(); e_pass.delete();
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < 8; k++) begin
        logic [39:0] e;
        int n;
        e = tt[k];
        push(c, b, 1, 0, k, p);
        b = e[2];
        n = (e[15:4] == 12'd0 ? 1 : int'(e[15:4])) * TD;
        for (int j = 0; j < n; j++)
          push(e[3] ? approach(c, e[39:16], j / TD) : e[39:16], b, 1, 0, k, p);
        c = e[39:16];
        if (e[1]) break;
      end
    push(c, b, 0, 1, -1, passes);
    for (int i = 0; i < 3; i++) push(c, b, 0, 0, -1, passes);
    m_rgb = c;
    m_blk = b;
  endtask

  task automatic chk_cycle(int c);
    chk($sformatf("rgb@%0d", c), 32'(rgb), e_rgb[c]);
    chk($sformatf("blink@%0d", c), 32'(blink_en), e_blk[c]);
    chk($sformatf("busy@%0d", c), 32'(busy), e_busy[c]);
    chk($sformatf("done@%0d", c), 32'(done), e_done[c]);
    if (e_idx[c] >= 0) chk($sformatf("idx@%0d", c), 32'(step_idx), e_idx[c]);
  endtask

  task automatic wr(int k, logic [23:0] c, int dur, bit f, bit b, bit l);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 3'(k);
    wr_data = {c, 12'(dur), f, b, l, 1'($urandom)};
    tt[k] = wr_data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // start, then compare every cycle; loop_en stays high until entry 1 of the last pass;
  // stray start pulses land only while busy; cut >= 0 stops comparing after that cycle
  task automatic play(int passes, int cut);
    build(passes);
    loop_en = passes > 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < e_rgb.size(); c++) begin
      if (c > 0) @(negedge clk);
      chk_cycle(c);
      loop_en = e_pass[c] < passes - 1 || (e_pass[c] == passes - 1 && e_idx[c] == 0 && passes > 1);
      start = e_busy[c] == 1 && $urandom_range(0, 2) == 0;
      if (c == cut) break;
    end
    start = 1'b0;
  endtask

  task automatic chk_dark(string tag);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_blink"}, 32'(blink_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    m_rgb = '0;
    m_blk = 1'b0;
    repeat (2) @(negedge clk);
    chk_dark("reset");
    chk("reset_idx", 32'(step_idx), 0);
    rst = 1'b0;
    // single red entry, duration 2, last
    wr(0, 24'hFF0000, 2, 0, 0, 1);
    play(1, -1);
    // black then fade red 00 -> 04 over 10 ticks
    wr(0, 24'h000000, 1, 0, 0, 0);
    wr(1, 24'h040000, 10, 1, 0, 1);
    play(1, -1);
    // three entries looped twice, loop_en dropped during entry 1 of the second pass
    wr(0, 24'h112233, 1, 0, 1, 0);
    wr(1, 24'h0A0B0C, 2, 1, 0, 0);
    wr(2, 24'h000005, 1, 0, 0, 1);
    play(2, -1);
    // stop in entry 1 run
    play(1, 8);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_dark("stop");
    repeat (3) begin
      @(negedge clk);
      chk_dark("after_stop");
    end
    m_rgb = '0;
    m_blk = 1'b0;
    // start and stop together while idle
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_dark("start_stop_idle");
    end
    // reset in the middle of a fade, then replay the untouched table
    play(1, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_dark("mid_rst");
    chk("mid_rst_idx", 32'(step_idx), 0);
    m_rgb = '0;
    m_blk = 1'b0;
    play(1, -1);
    // all eight entries, no last bits, some zero durations
    for (int k = 0; k < 8; k++)
      wr(k, 24'(k * 24'h030201), k % 3, k[0], k[1], 0);
    play(1, -1);
    // random tables
    repeat (6) begin
      for (int k = 0; k < 8; k++)
        wr(k, {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))},
           $urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      play(1, -1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rgb_led_sequencer.md
RGB_LED_SEQUENCER -- requirements
Module: rgb_led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27000; clk cycles per sequencer tick (1 ms at 27 MHz).
REQ-002 SHALL have parameter DEPTH, default 8; pattern table entries, fixed at 8 (3-bit index).
REQ-003 SHALL have port clk  input  1  system clock (27 MHz).
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  pattern table write strobe.
REQ-006 SHALL have port wr_addr  input  3  table entry index.
REQ-007 SHALL have port wr_data  input  40  entry: [39:16] rgb, [15:4] duration in ticks, [3] fade, [2] blink, [1] last, [0] reserved (ignored).
REQ-008 SHALL have port start  input  1  single-cycle start request.
REQ-009 SHALL have port stop  input  1  single-cycle abort request.
REQ-010 SHALL have port loop_en  input  1  restart at entry 0 after last entry; sampled at the end of each pass.
REQ-011 SHALL have port rgb  output  24  colour to the PWM LED driver.
REQ-012 SHALL have port blink_en  output  1  blink enable to the PWM LED driver.
REQ-013 SHALL have port busy  output  1  sequence running.
REQ-014 SHALL have port done  output  1  one-cycle pulse at normal completion.
REQ-015 SHALL have port step_idx  output  3  index of the active entry.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN: IDLE->LOAD on start; LOAD->RUN after one cycle; RUN->LOAD at entry expiry if another entry follows; RUN->IDLE at expiry of the final entry.
REQ-017 SHALL write wr_data into table[wr_addr] on every cycle with wr_en high, in any state; a write to the entry being read in LOAD becomes visible only from the next cycle.
REQ-018 SHALL, in the cycle after start is sampled in IDLE, assert busy, set step_idx=0, and enter LOAD.
REQ-019 SHALL, in LOAD, latch the entry at step_idx and clear the tick prescaler and duration counter; for a non-fade entry, rgb and blink_en take the entry values in the following cycle.
REQ-020 SHALL generate one tick every TICK_DIV clk cycles; the prescaler counts 0..TICK_DIV-1 and wraps.
REQ-021 SHALL keep each entry in RUN for max(duration,1) ticks; duration 0 behaves as 1.
REQ-022 SHALL, for a fade entry, set blink_en from the entry at LOAD and keep rgb at its previous value, then step each 8-bit channel by exactly 1 toward its target on every tick (no overshoot); at expiry, rgb snaps to the target.
REQ-023 SHALL treat an entry as final when its last bit is set or step_idx==7.
REQ-024 SHALL, at expiry of the final entry, go to LOAD with step_idx=0 if loop_en=1; otherwise go to IDLE, pulse done for one cycle, deassert busy, and hold rgb and blink_en.
REQ-025 SHALL, on stop in any non-IDLE state, enter IDLE in the next cycle with rgb=0, blink_en=0, busy=0, and no done pulse.
REQ-026 SHALL give stop priority when start and stop are high together; in IDLE this is a no-op.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL increment step_idx modulo 8 on the transition RUN->LOAD.

Reset
REQ-029 SHALL, with rst high at a clk edge, force state=IDLE, rgb=0, blink_en=0, busy=0, done=0, step_idx=0, prescaler=0, and duration counter=0, overriding all other inputs including mid-sequence.
REQ-030 SHALL leave table contents undefined after reset; they are not cleared.

Structure
REQ-031 SHALL take the entry field offsets and widths, the FSM state encoding, and DEPTH from shared package rgb_led_pkg.
REQ-032 SHALL implement the tick prescaler as sub-module tick_gen (parameter TICK_DIV; inputs clk, rst, clr; output tick).

Verification
REQ-033 SHALL cover: TICK_DIV=4; entry0={FF0000,dur 2,last}; start -> busy next cycle; rgb=FF0000 two cycles after start; done pulse 8 cycles after rgb update; busy=0 after the pulse; rgb held.
REQ-034 SHALL cover: entry0={000000,dur 1}, entry1={040000,dur 10,fade,last} -> red reads 01,02,03,04 on successive ticks and stays 04 until expiry; no overshoot.
REQ-035 SHALL cover: loop_en=1, three entries, last on entry2 -> step_idx 0,1,2,0,1 with no done pulse; clear loop_en during entry1 -> done after entry2.
REQ-036 SHALL cover: stop mid-RUN in entry1 -> next cycle rgb=0, blink_en=0, busy=0, no done; start and stop in the same cycle while IDLE -> stays IDLE.
REQ-037 SHALL cover: rst pulsed mid-fade -> all outputs at reset values next cycle; a subsequent start replays the table unchanged.
REQ-038 SHALL cover: no last bits set -> entries 0..7 play, then done; duration 0 entry lasts 1 tick.
